sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Sits directly upstream of the byte-addressed SDRAM controller and is the only block driving its rd/wr/refresh command inputs.
- Arbitrates two client ports onto the single controller command interface: VDP, which has priority, and CPU, which is protected from starvation.
- Generates periodic auto-refresh requests and tracks refresh debt.
- Routes read data and completion acks back to the client that was granted.

Parameters:
- REFRESH_INTERVAL, 780, clk cycles between refresh requests (≈14.4 us at 54 MHz).
- VDP_BURST, 4, max consecutive VDP grants while CPU is waiting before CPU is forced through.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- resetn  in  1  asynchronous active-low reset.
- vdp_req  in  1  VDP request level; held until vdp_ack.
- vdp_we  in  1  1=write, 0=read.
- vdp_addr  in  23  byte address.
- vdp_din  in  16  write data.
- vdp_wdm  in  2  write byte mask, active high = masked.
- vdp_dout  out  16  read data, registered.
- vdp_ack  out  1  one-cycle completion pulse.
- cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wdm, cpu_dout, cpu_ack: identical set for the CPU client.
- ctl_rd  out  1  read strobe to the controller.
- ctl_wr  out  1  write strobe to the controller.
- ctl_refresh  out  1  refresh strobe to the controller.
- ctl_addr  out  23  address to the controller.
- ctl_din  out  16  write data to the controller.
- ctl_wdm  out  2  write mask to the controller.
- ctl_dout  in  16  controller read data.
- ctl_data_ready  in  1  controller read-data valid.
- ctl_busy  in  1  controller busy.
- ctl_enabled  in  1  controller power-on delay has elapsed.

Behaviour:
- Reset: all outputs 0; state IDLE; timer=0; debt=0; vdp_streak=0; grant=NONE.
- Refresh timer:
  - Counts only while ctl_enabled=1; held at 0 otherwise.
  - On reaching REFRESH_INTERVAL-1 it wraps to 0 and increments debt.
  - debt is 2 bits and saturates at 3.
  - If a timer expiry and a refresh completion land in the same cycle, debt is unchanged.
- States: IDLE, START, RUN.
- IDLE:
  - Waits for ctl_enabled=1, ctl_busy=0, no ack asserted this cycle, and at least one source pending.
  - Selection priority:
    1. refresh, if debt>0;
    2. CPU, if cpu_req and vdp_streak==VDP_BURST;
    3. VDP, if vdp_req;
    4. CPU, if cpu_req.
  - On selection, registers exactly one strobe high for one cycle, plus ctl_addr/ctl_din/ctl_wdm from the winner.
  - Refresh drives only ctl_refresh.
  - Records grant and goes to START.
- START:
  - Strobes return to 0.
  - Waits for ctl_busy=1, then goes to RUN.
  - ctl_addr/din/wdm are held stable until the return to IDLE.
- RUN:
  - When ctl_data_ready=1 on a read grant, captures ctl_dout into the granted client's dout.
  - When ctl_busy=0, returns to IDLE and asserts that client's ack for exactly one cycle.
  - A refresh grant asserts no ack and decrements debt instead.
- vdp_streak:
  - Increments on each VDP grant while cpu_req=1, saturating at VDP_BURST.
  - Clears on any CPU grant, or when a VDP grant is made with cpu_req=0.
- Ack cycle: requests are not sampled in the cycle an ack is high. A client therefore drops req the cycle after ack without a spurious re-grant.
- Request stability: client addr/din/wdm/we must be stable while req=1. Dropping req before ack is illegal, and the in-flight operation completes regardless.
- Non-granted client: its dout holds its previous value.
- Latency: the strobe follows the qualifying req by 1 cycle. The end-to-end read ack follows the controller's busy fall by 1 cycle.
- ctl_enabled=0: no strobes are issued and requests stay pending.
- Asynchronous reset mid-operation: everything returns to reset values immediately and any pending ack is lost.

Test Plan:
- Single VDP read, addr=0x000102, with the bench controller model returning ctl_dout=0xBEEF -> ctl_rd pulses 1 cycle with ctl_addr=0x000102; vdp_dout=0xBEEF; vdp_ack 1 cycle; cpu_ack stays 0.
- CPU write, din=0x1234, wdm=2'b01 -> ctl_wr pulses with ctl_din=0x1234 and ctl_wdm=01; cpu_ack after busy falls; no data capture.
- vdp_req and cpu_req both held high continuously, VDP_BURST=4 -> grant order VDP,VDP,VDP,VDP,CPU, repeating.
- Idle bus with ctl_enabled=1 -> ctl_refresh every 780 cycles. Holding ctl_busy=1 for 3000 cycles -> debt saturates at 3, then 3 back-to-back refreshes are issued before a pending VDP request.
- ctl_enabled=0 with vdp_req=1 -> no strobes and timer stays at 0. Raising ctl_enabled -> the VDP read is issued within 2 cycles.
- resetn pulsed low while in RUN -> all outputs 0 immediately, debt=0, and no ack is emitted after reset release.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: VDP/CPU arbitration onto the single SDRAM controller port,
// with periodic auto-refresh generation and refresh-debt tracking.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int VDP_BURST        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vdp_req,
  input  logic        vdp_we,
  input  logic [22:0] vdp_addr,
  input  logic [15:0] vdp_din,
  input  logic [1:0]  vdp_wdm,
  output logic [15:0] vdp_dout,
  output logic        vdp_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wdm,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        ctl_rd,
  output logic        ctl_wr,
  output logic        ctl_refresh,
  output logic [22:0] ctl_addr,
  output logic [15:0] ctl_din,
  output logic [1:0]  ctl_wdm,
  input  logic [15:0] ctl_dout,
  input  logic        ctl_data_ready,
  input  logic        ctl_busy,
  input  logic        ctl_enabled
);

  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int SW = $clog2(VDP_BURST + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
  typedef enum logic [1:0] {
    G_NONE, G_VDP, G_CPU, G_REF
  } grant_t;

  state_t        state, state_n;
  grant_t        grant, grant_n;
  logic          gnt_we, gnt_we_n;
  logic [TW-1:0] timer;
  logic [1:0]    debt;
  logic [SW-1:0] streak, streak_n;
  logic          expire, ref_done;
  logic          any_ack, pend, go;
  logic          sel_ref, sel_cf, sel_v, sel_c;
  logic          rd_n, wr_n, ref_n;
  logic          vack_n, cack_n;
  logic [22:0]   addr_n;
  logic [15:0]   din_n, vdout_n, cdout_n;
  logic [1:0]    wdm_n;

  assign expire = ctl_enabled &&
                  (timer == TW'(REFRESH_INTERVAL - 1));
  assign ref_done = (state == RUN) && (grant == G_REF) &&
                    !ctl_busy;
  assign any_ack = vdp_ack | cpu_ack;
  assign pend = (debt != 2'd0) || vdp_req || cpu_req;
  assign go = ctl_enabled && !ctl_busy && !any_ack && pend;

  // one-hot winner; CPU is forced through after a full VDP streak
  assign sel_ref = debt != 2'd0;
  assign sel_cf = !sel_ref && cpu_req &&
                  (streak == SW'(VDP_BURST));
  assign sel_v = !sel_ref && !sel_cf && vdp_req;
  assign sel_c = !sel_ref && !sel_cf && !sel_v && cpu_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (!ctl_enabled || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      debt <= 2'd0;
    end else begin
      unique case ({expire, ref_done})
        2'b10: if (debt != 2'd3) debt <= debt + 2'd1;
        2'b01: if (debt != 2'd0) debt <= debt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= G_NONE;
      gnt_we      <= 1'b0;
      streak      <= '0;
      ctl_rd      <= 1'b0;
      ctl_wr      <= 1'b0;
      ctl_refresh <= 1'b0;
      ctl_addr    <= '0;
      ctl_din     <= '0;
      ctl_wdm     <= '0;
      vdp_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      vdp_dout    <= '0;
      cpu_dout    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      gnt_we      <= gnt_we_n;
      streak      <= streak_n;
      ctl_rd      <= rd_n;
      ctl_wr      <= wr_n;
      ctl_refresh <= ref_n;
      ctl_addr    <= addr_n;
      ctl_din     <= din_n;
      ctl_wdm     <= wdm_n;
      vdp_ack     <= vack_n;
      cpu_ack     <= cack_n;
      vdp_dout    <= vdout_n;
      cpu_dout    <= cdout_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    gnt_we_n = gnt_we;
    streak_n = streak;
    rd_n     = 1'b0;
    wr_n     = 1'b0;
    ref_n    = 1'b0;
    vack_n   = 1'b0;
    cack_n   = 1'b0;
    addr_n   = ctl_addr;
    din_n    = ctl_din;
    wdm_n    = ctl_wdm;
    vdout_n  = vdp_dout;
    cdout_n  = cpu_dout;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = START;
          unique case (1'b1)
            sel_ref: begin
              grant_n  = G_REF;
              gnt_we_n = 1'b0;
              ref_n    = 1'b1;
            end
            sel_v: begin
              grant_n  = G_VDP;
              gnt_we_n = vdp_we;
              rd_n     = !vdp_we;
              wr_n     = vdp_we;
              addr_n   = vdp_addr;
              din_n    = vdp_din;
              wdm_n    = vdp_wdm;
              streak_n = cpu_req ? streak + SW'(1) : '0;
            end
            sel_cf, sel_c: begin
              grant_n  = G_CPU;
              gnt_we_n = cpu_we;
              rd_n     = !cpu_we;
              wr_n     = cpu_we;
              addr_n   = cpu_addr;
              din_n    = cpu_din;
              wdm_n    = cpu_wdm;
              streak_n = '0;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      START: begin
        if (ctl_busy) state_n = RUN;
      end
      RUN: begin
        if (ctl_data_ready && !gnt_we) begin
          if (grant == G_VDP) vdout_n = ctl_dout;
          if (grant == G_CPU) cdout_n = ctl_dout;
        end
        if (!ctl_busy) begin
          state_n = IDLE;
          grant_n = G_NONE;
          vack_n  = grant == G_VDP;
          cack_n  = grant == G_CPU;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized and directed checks of sdram_arbiter
// against a transaction-level model and a simple controller model.
module tb_sdram_arbiter;

  localparam int VB = 4;
  localparam int RI = 780;

  logic        clk, resetn;
  logic        vdp_req, vdp_we, cpu_req, cpu_we;
  logic [22:0] vdp_addr, cpu_addr, ctl_addr;
  logic [15:0] vdp_din, cpu_din, vdp_dout, cpu_dout;
  logic [1:0]  vdp_wdm, cpu_wdm, ctl_wdm;
  logic        vdp_ack, cpu_ack;
  logic        ctl_rd, ctl_wr, ctl_refresh;
  logic [15:0] ctl_din, ctl_dout;
  logic        ctl_data_ready, ctl_busy, ctl_enabled;
  logic        m_busy = 1'b0;
  logic        f_busy = 1'b0;

  assign ctl_busy = m_busy | f_busy;

  sdram_arbiter #(.REFRESH_INTERVAL(RI), .VDP_BURST(VB)) dut (
    .clk(clk), .resetn(resetn),
    .vdp_req(vdp_req), .vdp_we(vdp_we), .vdp_addr(vdp_addr),
    .vdp_din(vdp_din), .vdp_wdm(vdp_wdm), .vdp_dout(vdp_dout),
    .vdp_ack(vdp_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_wdm(cpu_wdm), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack),
    .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh),
    .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_wdm(ctl_wdm),
    .ctl_dout(ctl_dout), .ctl_data_ready(ctl_data_ready),
    .ctl_busy(ctl_busy), .ctl_enabled(ctl_enabled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [15:0] ctl_mem [logic [22:0]];
  logic [15:0] ref_mem [logic [22:0]];

  function automatic logic [15:0] dflt(input logic [22:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] rd_ctl(input logic [22:0] a);
    if (ctl_mem.exists(a)) return ctl_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] rd_ref(input logic [22:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o,
      input logic [15:0] d, input logic [1:0] m);
    logic [15:0] r;
    r = o;
    if (!m[0]) r[7:0] = d[7:0];
    if (!m[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // transaction-level model state: 0 none, 1 VDP, 2 CPU, 3 refresh
  int          inflight = 0;
  int          streak_m = 0;
  logic        fwe;
  logic [22:0] fa;
  logic [15:0] fd;
  logic [1:0]  fm;
  logic [15:0] exp_vd = '0, exp_cd = '0;
  logic        s_v = 1'b0, s_c = 1'b0;
  logic        prev_stb = 1'b0, prev_busy = 1'b0;
  int          fall_cyc = 0;
  int          m_cnt = 0;
  logic        m_rd;
  logic [22:0] m_a;
  int          gq[$];
  int          gcyc[$];
  int          rcyc[$];
  int          n_ack = 0;
  int          n_ref = 0;

  always @(negedge clk) begin
    int          win, nst;
    logic        bn, cwe;
    logic [22:0] ca;
    logic [15:0] cd;
    logic [1:0]  cm;
    if (!resetn) begin
      inflight = 0;
      streak_m = 0;
      exp_vd = '0;
      exp_cd = '0;
      m_busy = 1'b0;
      m_cnt = 0;
      ctl_data_ready = 1'b0;
      ctl_dout = '0;
      prev_stb = 1'b0;
    end else begin
      if (vdp_ack || cpu_ack) begin
        n_ack++;
        chk("ack_owner", {vdp_ack, cpu_ack},
            inflight == 1 ? 2'b10 : inflight == 2 ? 2'b01 : 2'b00);
        chk("ack_latency", cyc - fall_cyc, 1);
        if (inflight == 1 || inflight == 2) begin
          if (fwe) ref_mem[fa] = merge(rd_ref(fa), fd, fm);
          else if (inflight == 1) exp_vd = rd_ref(fa);
          else exp_cd = rd_ref(fa);
        end
        chk("vdp_dout", vdp_dout, exp_vd);
        chk("cpu_dout", cpu_dout, exp_cd);
        inflight = 0;
      end
      nst = int'(ctl_rd) + int'(ctl_wr) + int'(ctl_refresh);
      ctl_data_ready = 1'b0;
      ctl_dout = 16'($urandom);
      if (nst != 0) begin
        chk("one_strobe", nst, 1);
        chk("strobe_width", prev_stb, 0);
        chk("strobe_overlap", inflight, 0);
        if (ctl_refresh) begin
          inflight = 3;
          n_ref++;
          gq.push_back(3);
          gcyc.push_back(cyc);
          rcyc.push_back(cyc);
        end else begin
          win = (s_c && streak_m == VB) ? 2 : (s_v ? 1 : 2);
          chk("winner_req", win == 1 ? s_v : s_c, 1);
          if (win == 1) begin
            cwe = vdp_we; ca = vdp_addr; cd = vdp_din; cm = vdp_wdm;
            streak_m = s_c ? (streak_m < VB ? streak_m + 1 : VB) : 0;
          end else begin
            cwe = cpu_we; ca = cpu_addr; cd = cpu_din; cm = cpu_wdm;
            streak_m = 0;
          end
          chk("strobe_dir", ctl_wr, cwe);
          chk("ctl_addr", ctl_addr, ca);
          if (cwe) begin
            chk("ctl_din", ctl_din, cd);
            chk("ctl_wdm", ctl_wdm, cm);
          end
          inflight = win;
          fwe = cwe; fa = ca; fd = cd; fm = cm;
          gq.push_back(win);
          gcyc.push_back(cyc);
        end
        m_busy = 1'b1;
        m_cnt = $urandom_range(5, 2);
        m_rd = ctl_rd;
        m_a = ctl_addr;
        if (ctl_wr)
          ctl_mem[ctl_addr] = merge(rd_ctl(ctl_addr), ctl_din, ctl_wdm);
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 1 && m_rd) begin
          ctl_data_ready = 1'b1;
          ctl_dout = rd_ctl(m_a);
        end
        if (m_cnt == 0) m_busy = 1'b0;
      end
      prev_stb = nst != 0;
    end
    bn = m_busy | f_busy;
    if (prev_busy && !bn) begin
      fall_cyc = cyc;
      if (inflight == 3) inflight = 0;
    end
    prev_busy = bn;
    s_v = vdp_req;
    s_c = cpu_req;
  end

  task automatic client_op(input int c, input logic we,
      input logic [22:0] a, input logic [15:0] d, input logic [1:0] m);
    bit got;
    @(posedge clk); #1;
    if (c == 0) begin
      vdp_we = we; vdp_addr = a; vdp_din = d; vdp_wdm = m; vdp_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_din = d; cpu_wdm = m; cpu_req = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(posedge clk); #1;
      got = (c == 0) ? vdp_ack : cpu_ack;
    end
    chk(c == 0 ? "vdp_ack_timeout" : "cpu_ack_timeout", got, 1);
    if (c == 0) vdp_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic wait_vdp_ack(input int lim, output bit got);
    got = 0;
    for (int k = 0; k < lim && !got; k++) begin
      @(posedge clk); #1;
      got = vdp_ack;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, n, k, e_cyc;
    bit          got;
    int          seq[$];
    logic [15:0] old, w;

    resetn = 1'b0;
    ctl_enabled = 1'b1;
    vdp_req = 0; vdp_we = 0; vdp_addr = '0; vdp_din = '0; vdp_wdm = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0; cpu_wdm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", |{vdp_dout, vdp_ack, cpu_dout, cpu_ack, ctl_rd,
        ctl_wr, ctl_refresh, ctl_addr, ctl_din, ctl_wdm}, 0);
    resetn = 1'b1;

    ctl_mem[23'h000102] = 16'hBEEF;
    ref_mem[23'h000102] = 16'hBEEF;
    client_op(0, 1'b0, 23'h000102, 16'h0, 2'b00);
    chk("t1_vdp_dout", vdp_dout, 16'hBEEF);
    chk("t1_grant", gq[$], 1);
    chk("t1_cpu_dout", cpu_dout, 16'h0);

    old = dflt(23'h0002A0);
    client_op(1, 1'b1, 23'h0002A0, 16'h1234, 2'b01);
    chk("t2_grant", gq[$], 2);
    chk("t2_cpu_dout", cpu_dout, 16'h0);
    client_op(0, 1'b0, 23'h0002A0, 16'h0, 2'b00);
    chk("t2_readback", vdp_dout, {8'h12, old[7:0]});

    base = gq.size();
    vdp_we = 0; vdp_addr = 23'h200; cpu_we = 0; cpu_addr = 23'h300;
    vdp_req = 1'b1;
    cpu_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20000 && n < 10; i++) begin
      @(posedge clk); #1;
      if (vdp_ack || cpu_ack) n++;
    end
    vdp_req = 1'b0;
    cpu_req = 1'b0;
    chk("t3_acks", n, 10);
    for (int i = base; i < gq.size(); i++)
      if (gq[i] != 3) seq.push_back(gq[i]);
    chk("t3_count", seq.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("t3_order", seq.size() > i ? seq[i] : -1,
          (i % 5 == 4) ? 2 : 1);

    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(2, 0)) @(posedge clk);
        client_op(0, 1'($urandom_range(1, 0)),
                  23'h10 + 23'(2 * $urandom_range(3, 0)),
                  16'($urandom), 2'($urandom_range(3, 0)));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(2, 0)) @(posedge clk);
        client_op(1, 1'($urandom_range(1, 0)),
                  23'h14 + 23'(2 * $urandom_range(3, 0)),
                  16'($urandom), 2'($urandom_range(3, 0)));
      end
    join

    k = n_ref;
    for (int i = 0; i < 3000 && n_ref < k + 3; i++) @(posedge clk);
    chk("t4_refs", n_ref - k, 3);
    if (rcyc.size() >= 2)
      chk("t4_period", rcyc[$] - rcyc[$-1], RI);

    repeat (10) @(posedge clk);
    #1;
    f_busy = 1'b1;
    vdp_we = 0; vdp_addr = 23'h400; vdp_req = 1'b1;
    base = gq.size();
    repeat (3200) @(posedge clk);
    #1;
    chk("t5_hold_quiet", gq.size() - base, 0);
    f_busy = 1'b0;
    wait_vdp_ack(200, got);
    vdp_req = 1'b0;
    chk("t5_ack", got, 1);
    chk("t5_count", gq.size() - base, 4);
    for (int i = 0; i < 4; i++)
      chk("t5_order", gq.size() > base + i ? gq[base + i] : -1,
          i < 3 ? 3 : 1);

    repeat (5) @(posedge clk);
    #1;
    ctl_enabled = 1'b0;
    vdp_we = 0; vdp_addr = 23'h500; vdp_req = 1'b1;
    base = gq.size();
    repeat (60) @(posedge clk);
    #1;
    chk("t6_quiet", gq.size() - base, 0);
    ctl_enabled = 1'b1;
    e_cyc = cyc;
    wait_vdp_ack(200, got);
    vdp_req = 1'b0;
    chk("t6_ack", got, 1);
    chk("t6_grant", gq.size() > base ? gq[base] : -1, 1);
    chk("t6_latency", gcyc.size() > base ? gcyc[base] - e_cyc : -1, 1);
    k = n_ref;
    for (int i = 0; i < 1000 && n_ref == k; i++) @(posedge clk);
    chk("t6_refresh", n_ref - k, 1);
    chk("t6_ref_delay", rcyc[$] - e_cyc, RI + 1);

    repeat (10) @(posedge clk);
    #1;
    vdp_we = 0; vdp_addr = 23'h600; vdp_req = 1'b1;
    base = gq.size();
    for (int i = 0; i < 50 && gq.size() == base; i++) begin
      @(posedge clk); #1;
    end
    f_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("t7_outs_zero", |{vdp_dout, vdp_ack, cpu_dout, cpu_ack, ctl_rd,
        ctl_wr, ctl_refresh, ctl_addr, ctl_din, ctl_wdm}, 0);
    vdp_req = 1'b0;
    f_busy = 1'b0;
    k = n_ack;
    base = gq.size();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t7_no_ack", n_ack - k, 0);
    chk("t7_no_strobe", gq.size() - base, 0);
    chk("t7_vdp_dout", vdp_dout, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
